// File: rtl/lr_shift_iter.sv
// Multi-cycle logical left/right shifter, one bit position per clock, valid/ready on both sides.
// Optional circular mode is enabled by defining LR_SHIFT_ITER_ROTATE_EN (adds the rotate port).

package lr_shift_iter_pkg;
    typedef enum logic {
        ShiftDir_Left  = 1'b0,
        ShiftDir_Right = 1'b1
    } t_enum_ShiftDir;
endpackage

module lr_shift_iter
    import lr_shift_iter_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iValid,
    output logic                     iReady,
    input  logic [width-1:0]         iBits,
    input  logic [$clog2(width)-1:0] shift,
    input  t_enum_ShiftDir           dir,
`ifdef LR_SHIFT_ITER_ROTATE_EN
    input  logic                     rotate,
`endif
    output logic                     oValid,
    input  logic                     oReady,
    output logic [width-1:0]         oBits,
    output logic                     busy
);

    localparam int unsigned SW = $clog2(width);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [width-1:0] data_q, data_d;
    logic [SW-1:0]  count_q, count_d;
    t_enum_ShiftDir dir_q, dir_d;
    logic           fill;

`ifdef LR_SHIFT_ITER_ROTATE_EN
    logic rot_q, rot_d;

    // Circular mode re-inserts the bit leaving the word.
    always_comb begin
        fill = 1'b0;
        if (rot_q) begin
            fill = (dir_q == ShiftDir_Left) ? data_q[width-1] : data_q[0];
        end
    end
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        dir_d   = dir_q;
`ifdef LR_SHIFT_ITER_ROTATE_EN
        rot_d   = rot_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (iValid) begin
                    data_d  = iBits;
                    count_d = shift;
                    dir_d   = dir;
`ifdef LR_SHIFT_ITER_ROTATE_EN
                    rot_d   = rotate;
`endif
                    state_d = (shift != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                data_d  = (dir_q == ShiftDir_Left) ? {data_q[width-2:0], fill}
                                                   : {fill, data_q[width-1:1]};
                count_d = count_q - SW'(1);
                if (count_q == SW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (oReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
            dir_q   <= ShiftDir_Left;
`ifdef LR_SHIFT_ITER_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            dir_q   <= dir_d;
`ifdef LR_SHIFT_ITER_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Outputs decode from registered state only.
    assign iReady = (state_q == StIdle);
    assign oValid = (state_q == StDone);
    assign busy   = (state_q != StIdle);
    assign oBits  = data_q;

endmodule
